// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: FSM state encodings,
// default PC width, the width of the squash counter and the "take" helper.
package branch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_SQUASH   = 2'b10
    } br_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int FLUSH_W    = 4;

    // A resolved branch requests a redirect only when it is valid, is a branch and was taken.
    function automatic logic is_take(input logic valid, input logic is_branch, input logic sel);
        return valid & is_branch & sel;
    endfunction

endpackage

// File: rtl/branch_stat_counter.sv
// Free-running statistics counter with enable; wraps at 2^CNT_W.
module branch_stat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count enabled cycles; natural modulo-2^CNT_W wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= {CNT_W{1'b0}};
        end else if (en) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: samples the EX branch decision, drives the
// fetch-side redirect handshake and squashes IF/ID and ID/EX until fetch has
// taken the new PC plus FLUSH_CYCLES drain cycles.
// Optional statistics counters are built when BRANCH_STATS_EN is defined;
// otherwise the stat_* ports are tied to zero.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic              br_sel,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              redirect_ready,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [CNT_W-1:0]  stat_branches,
    output logic [CNT_W-1:0]  stat_taken,
    output logic [CNT_W-1:0]  stat_wait
);

    localparam logic [FLUSH_W-1:0] FLUSH_LD = FLUSH_W'(FLUSH_CYCLES);

    br_state_e          state_r, state_s;
    logic [FLUSH_W-1:0] cnt_r, cnt_s;
    logic [ADDR_W-1:0]  pc_r, pc_s;
    logic               valid_r, valid_s;
    logic               flush_ifid_r, flush_idex_r, flush_s;
    logic               take_s;

    assign take_s = is_take(ex_valid, ex_is_branch, br_sel);

    // Next-state logic; outputs are derived from the next state so they can be registered.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pc_s    = pc_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_s = ST_REDIRECT;
                    pc_s    = br_target;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_LD == 4'd0) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_SQUASH;
                        cnt_s   = FLUSH_LD;
                    end
                end else begin
                    state_s = ST_REDIRECT;
                end
            end
            ST_SQUASH: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end else begin
                    state_s = ST_SQUASH;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
        valid_s = (state_s == ST_REDIRECT);
        flush_s = (state_s != ST_IDLE);
    end

    // State, squash counter, captured target and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            pc_r         <= {ADDR_W{1'b0}};
            valid_r      <= 1'b0;
            flush_ifid_r <= 1'b0;
            flush_idex_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            pc_r         <= pc_s;
            valid_r      <= valid_s;
            flush_ifid_r <= flush_s;
            flush_idex_r <= flush_s;
        end
    end

    assign redirect_valid = valid_r;
    assign redirect_pc    = pc_r;
    assign flush_ifid     = flush_ifid_r;
    assign flush_idex     = flush_idex_r;

`ifdef BRANCH_STATS_EN
    logic br_en_s, tk_en_s, wt_en_s;

    assign br_en_s = (state_r == ST_IDLE) & ex_valid & ex_is_branch;
    assign tk_en_s = (state_r == ST_IDLE) & take_s;
    assign wt_en_s = (state_r == ST_REDIRECT) & ~redirect_ready;

    branch_stat_counter #(.CNT_W(CNT_W)) u_stat_branches (
        .clk(clk), .reset(reset), .en(br_en_s), .count(stat_branches)
    );
    branch_stat_counter #(.CNT_W(CNT_W)) u_stat_taken (
        .clk(clk), .reset(reset), .en(tk_en_s), .count(stat_taken)
    );
    branch_stat_counter #(.CNT_W(CNT_W)) u_stat_wait (
        .clk(clk), .reset(reset), .en(wt_en_s), .count(stat_wait)
    );
`else
    assign stat_branches = {CNT_W{1'b0}};
    assign stat_taken    = {CNT_W{1'b0}};
    assign stat_wait     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Testbench for branch_redirect_ctrl: two instances (FLUSH_CYCLES=1 and 0)
// driven by the same directed and random stimulus, compared each cycle
// against a transaction-level reference model.
module tb_branch_redirect_ctrl;

    localparam int AW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ex_valid = 1'b0;
    logic          ex_is_branch = 1'b0;
    logic          br_sel = 1'b0;
    logic [AW-1:0] br_target = 32'h0;
    logic          redirect_ready = 1'b0;

    logic          rv0, fi0, fe0, rv1, fi1, fe1;
    logic [AW-1:0] pc0, pc1;
    logic [CW-1:0] sb0, st0, sw0, sb1, st1, sw1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: per instance, whether a redirect is outstanding,
    // how many drain cycles remain, the promised PC and event tallies.
    int          flush_cfg[2] = '{1, 0};
    bit          m_pending[2];
    int          m_drain[2];
    logic [31:0] m_pc[2];
    int          m_br[2], m_tk[2], m_wt[2];

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(1), .CNT_W(CW)) dut0 (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .br_sel(br_sel), .br_target(br_target), .redirect_ready(redirect_ready),
        .redirect_valid(rv0), .redirect_pc(pc0), .flush_ifid(fi0), .flush_idex(fe0),
        .stat_branches(sb0), .stat_taken(st0), .stat_wait(sw0)
    );

    branch_redirect_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(0), .CNT_W(CW)) dut1 (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .br_sel(br_sel), .br_target(br_target), .redirect_ready(redirect_ready),
        .redirect_valid(rv1), .redirect_pc(pc1), .flush_ifid(fi1), .flush_idex(fe1),
        .stat_branches(sb1), .stat_taken(st1), .stat_wait(sw1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pending[k] = 1'b0;
            m_drain[k]   = 0;
            m_pc[k]      = 32'h0;
            m_br[k]      = 0;
            m_tk[k]      = 0;
            m_wt[k]      = 0;
        end
    endtask

    // Apply one clock edge of the rules to the model using the sampled inputs.
    task automatic model_edge();
        bit take;
        take = ex_valid & ex_is_branch & br_sel;
        for (int k = 0; k < 2; k++) begin
            if (!m_pending[k] && m_drain[k] == 0) begin
                if (ex_valid && ex_is_branch) m_br[k]++;
                if (take) begin
                    m_tk[k]++;
                    m_pending[k] = 1'b1;
                    m_pc[k]      = br_target;
                end
            end else if (m_pending[k]) begin
                if (redirect_ready) begin
                    m_pending[k] = 1'b0;
                    m_drain[k]   = flush_cfg[k];
                end else begin
                    m_wt[k]++;
                end
            end else begin
                m_drain[k]--;
            end
        end
    endtask

    task automatic check_dut(input int k, input string nm, input logic rv, input logic [AW-1:0] pc,
                             input logic fi, input logic fe,
                             input logic [CW-1:0] sb, input logic [CW-1:0] st, input logic [CW-1:0] sw);
        logic exp_flush;
        exp_flush = m_pending[k] || (m_drain[k] > 0);
        check({nm, ".redirect_valid"}, 64'(rv), 64'(m_pending[k]));
        check({nm, ".redirect_pc"},    64'(pc), 64'(m_pc[k]));
        check({nm, ".flush_ifid"},     64'(fi), 64'(exp_flush));
        check({nm, ".flush_idex"},     64'(fe), 64'(exp_flush));
`ifdef BRANCH_STATS_EN
        check({nm, ".stat_branches"}, 64'(sb), 64'(m_br[k]));
        check({nm, ".stat_taken"},    64'(st), 64'(m_tk[k]));
        check({nm, ".stat_wait"},     64'(sw), 64'(m_wt[k]));
`else
        check({nm, ".stat_branches"}, 64'(sb), 64'h0);
        check({nm, ".stat_taken"},    64'(st), 64'h0);
        check({nm, ".stat_wait"},     64'(sw), 64'h0);
`endif
    endtask

    task automatic check_all();
        check_dut(0, "f1", rv0, pc0, fi0, fe0, sb0, st0, sw0);
        check_dut(1, "f0", rv1, pc1, fi1, fe1, sb1, st1, sw1);
    endtask

    // Drive inputs for one cycle, let the edge happen, update model, compare.
    task automatic step(input logic v, input logic b, input logic s,
                        input logic [AW-1:0] t, input logic r);
        ex_valid       = v;
        ex_is_branch   = b;
        br_sel         = s;
        br_target      = t;
        redirect_ready = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Assert reset between edges, check outputs clear asynchronously, release.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Reset mid-REDIRECT
        step(1'b1, 1'b1, 1'b1, 32'h0040_0100, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("mid_redirect_pc", 64'(pc0), 64'h0040_0100);
        async_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Immediate ready
        step(1'b1, 1'b1, 1'b1, 32'h0040_0020, 1'b1);
        check("imm_valid", 64'(rv0), 64'h1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("imm_squash_flush", 64'(fi0), 64'h1);
        check("f0_idle_flush", 64'(fi1), 64'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("imm_idle_flush", 64'(fi0), 64'h0);

        // Ready low 3 cycles, second taken branch during REDIRECT and SQUASH
        async_reset();
        step(1'b1, 1'b1, 1'b1, 32'h0040_0200, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b1, 32'h0000_0BAD, 1'b0);
        check("wait_pc_held", 64'(pc0), 64'h0040_0200);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0BAD, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0BAD, 1'b1);
        check("ignored_pc", 64'(pc0), 64'h0040_0200);

        // Not-taken beq and non-branch with br_sel
        async_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0040_0300, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h0040_0400, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("nottaken_valid", 64'(rv0), 64'h0);

        // Randomised traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                async_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 2) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule
